pxs_split_n: RTL and testbench

- Copies one 26-bit pixel stream into NUM_OUT output streams.
- Each output has its own programmable delay of 0..MAX_DLY pixel clocks and its own enable. Parallel branches with different processing latencies can therefore be re-aligned before a merge stage.
- Configuration changes take effect only at a frame boundary, so no branch ever shows a torn frame.
- Sits at fork points of the pixel pipeline; it is the generalised successor of the fixed 2-way splitter.

---
 rtl/pxs_pkg.sv | 20 ++
 rtl/pxs_dly_line.sv | 37 +++
 rtl/pxs_split_n.sv | 171 +++++++++++++++++
 tb/tb_pxs_split_n.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pxs_pkg.sv
// Pixel stream word definitions shared by the stream fork blocks.
// Word layout: [23:0] RGB, [24] hsync, [25] vsync.
package pxs_pkg;

  localparam int PXS_W       = 26;
  localparam int PXS_VS      = 25;
  localparam int PXS_HS      = 24;
  localparam int PXS_RGB_MSB = 23;

  typedef logic [PXS_W-1:0] pxs_t;

  // Word driven by a disabled branch: no sync, black pixel.
  localparam pxs_t PXS_BLANK = '0;

  // Vertical sync flag of a stream word.
  function automatic logic pxs_vsync(input pxs_t w);
    return w[PXS_VS];
  endfunction

endpackage

// File: rtl/pxs_dly_line.sv
// Tapped shift chain for pixel words. Tap 0 registers the input word,
// tap n holds the word that entered tap 0 n clocks earlier. All taps are
// exported flattened: tap n at [n*PXS_W +: PXS_W].
module pxs_dly_line #(
  parameter int PXS_W = 26,
  parameter int DEPTH = 8
) (
  input  logic                   px_clk,
  input  logic                   rst_n,
  input  logic [PXS_W-1:0]       din_i,
  output logic [DEPTH*PXS_W-1:0] taps_o
);

  logic [PXS_W-1:0] tap_q [DEPTH];

  // Shift the chain by one word every clock; reset flushes every tap.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < DEPTH; n++) begin
        tap_q[n] <= '0;
      end
    end else begin
      tap_q[0] <= din_i;
      for (int n = 1; n < DEPTH; n++) begin
        tap_q[n] <= tap_q[n-1];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_taps
      assign taps_o[gi*PXS_W +: PXS_W] = tap_q[gi];
    end
  endgenerate

endmodule

// File: rtl/pxs_split_n.sv
// Pixel stream fork: copies one stream into NUM_OUT outputs, each with its
// own delay (0..MAX_DLY clocks on top of a 2-clock base latency) and enable.
// New configuration is held pending and applied at the next vsync rise so
// that no branch shows a torn frame.
// Optional macro PXS_SPLIT_IMM_EN adds cfg_imm_i for immediate writes that
// bypass the frame-synchronous pending stage.
module pxs_split_n
  import pxs_pkg::*;
#(
  parameter int NUM_OUT = 2,
  parameter int MAX_DLY = 7,
  parameter int DLY_W   = (MAX_DLY < 1) ? 1 : $clog2(MAX_DLY + 1)
) (
  input  logic                     px_clk,
  input  logic                     rst_n,
  input  logic [PXS_W-1:0]         str_i,
  output logic [NUM_OUT*PXS_W-1:0] str_o,
  input  logic                     cfg_wr_i,
`ifdef PXS_SPLIT_IMM_EN
  input  logic                     cfg_imm_i,
`endif
  input  logic [NUM_OUT*DLY_W-1:0] cfg_dly_i,
  input  logic [NUM_OUT-1:0]       cfg_en_i,
  output logic                     cfg_pend_o
);

  localparam int               DEPTH     = MAX_DLY + 1;
  localparam logic [DLY_W-1:0] MAX_DLY_F = DLY_W'(MAX_DLY);

  // ---------------------------------------------------------------- chain
  logic [DEPTH*PXS_W-1:0] taps_flat;
  pxs_t                   tap_w [DEPTH];

  pxs_dly_line #(
    .PXS_W (PXS_W),
    .DEPTH (DEPTH)
  ) u_dly_line (
    .px_clk (px_clk),
    .rst_n  (rst_n),
    .din_i  (str_i),
    .taps_o (taps_flat)
  );

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_unpack
      assign tap_w[gi] = taps_flat[gi*PXS_W +: PXS_W];
    end
  endgenerate

  // ---------------------------------------------------------- frame start
  logic vs_q;
  logic frame_start;

  // Remember last vsync level so a rising edge on the input can be seen.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
    end else begin
      vs_q <= pxs_vsync(str_i);
    end
  end

  assign frame_start = pxs_vsync(str_i) & ~vs_q;

  // ------------------------------------------------------------- config
  logic [NUM_OUT*DLY_W-1:0] cfg_dly_clamp;

  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_clamp
      assign cfg_dly_clamp[gi*DLY_W +: DLY_W] =
        (cfg_dly_i[gi*DLY_W +: DLY_W] > MAX_DLY_F) ? MAX_DLY_F
                                                   : cfg_dly_i[gi*DLY_W +: DLY_W];
    end
  endgenerate

  logic wr_imm;
  logic wr_frm;
  logic apply;

`ifdef PXS_SPLIT_IMM_EN
  assign wr_imm = cfg_wr_i & cfg_imm_i;
`else
  assign wr_imm = 1'b0;
`endif
  assign wr_frm = cfg_wr_i & ~wr_imm;

  logic [NUM_OUT*DLY_W-1:0] act_dly_q, act_dly_d;
  logic [NUM_OUT-1:0]       act_en_q,  act_en_d;
  logic [NUM_OUT*DLY_W-1:0] pnd_dly_q, pnd_dly_d;
  logic [NUM_OUT-1:0]       pnd_en_q,  pnd_en_d;
  logic                     pend_q,    pend_d;

  assign apply = frame_start & pend_q;

  // Config next state. An immediate write overrides everything; otherwise
  // the apply uses the old pending values even when a write lands on the
  // same clock, and that write then becomes the new pending config.
  always_comb begin
    act_dly_d = act_dly_q;
    act_en_d  = act_en_q;
    pnd_dly_d = pnd_dly_q;
    pnd_en_d  = pnd_en_q;
    pend_d    = pend_q;
    if (wr_imm) begin
      act_dly_d = cfg_dly_clamp;
      act_en_d  = cfg_en_i;
      pend_d    = 1'b0;
    end else begin
      if (apply) begin
        act_dly_d = pnd_dly_q;
        act_en_d  = pnd_en_q;
        pend_d    = 1'b0;
      end
      if (wr_frm) begin
        pnd_dly_d = cfg_dly_clamp;
        pnd_en_d  = cfg_en_i;
        pend_d    = 1'b1;
      end
    end
  end

  // Config registers; reset gives zero delay with every output enabled.
  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      act_dly_q <= '0;
      act_en_q  <= '1;
      pnd_dly_q <= '0;
      pnd_en_q  <= '0;
      pend_q    <= 1'b0;
    end else begin
      act_dly_q <= act_dly_d;
      act_en_q  <= act_en_d;
      pnd_dly_q <= pnd_dly_d;
      pnd_en_q  <= pnd_en_d;
      pend_q    <= pend_d;
    end
  end

  assign cfg_pend_o = pend_q;

  // ------------------------------------------------------------- outputs
  generate
    for (gi = 0; gi < NUM_OUT; gi++) begin : g_out
      pxs_t tap_sel;
      pxs_t out_q;

      // Select the tap matching this output's active delay.
      always_comb begin
        tap_sel = tap_w[0];
        for (int n = 1; n < DEPTH; n++) begin
          if (act_dly_q[gi*DLY_W +: DLY_W] == DLY_W'(n)) begin
            tap_sel = tap_w[n];
          end
        end
      end

      // Register the selected word, blanked when the output is disabled.
      always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q <= PXS_BLANK;
        end else begin
          out_q <= act_en_q[gi] ? tap_sel : PXS_BLANK;
        end
      end

      assign str_o[gi*PXS_W +: PXS_W] = out_q;
    end
  endgenerate

endmodule

// File: tb/tb_pxs_split_n.sv
// Bench for pxs_split_n: a directed vector table, hand sequences for the
// multi-cycle corners, then random traffic against a history-based model.
// Two instances run side by side: MAX_DLY=7 and MAX_DLY=5 (clamp active).
// Define PXS_SPLIT_IMM_EN to also exercise immediate writes.
module tb_pxs_split_n;

  localparam int          NO   = 2;
  localparam int          DW   = 3;
  localparam int          HMAX = 8192;
  localparam logic [25:0] VS   = 26'h2000000;

  logic             px_clk  = 1'b0;
  logic             rst_n   = 1'b0;
  logic [25:0]      str_i   = '0;
  logic             cfg_wr  = 1'b0;
  logic [NO*DW-1:0] cfg_dly = '0;
  logic [NO-1:0]    cfg_en  = '0;
  logic             cfg_imm = 1'b0;
  logic [NO*26-1:0] str_o_a, str_o_b;
  logic             pend_a, pend_b;

  always #5 px_clk = ~px_clk;

  pxs_split_n #(.NUM_OUT(NO), .MAX_DLY(7)) dut_a (
    .px_clk     (px_clk),
    .rst_n      (rst_n),
    .str_i      (str_i),
    .str_o      (str_o_a),
    .cfg_wr_i   (cfg_wr),
`ifdef PXS_SPLIT_IMM_EN
    .cfg_imm_i  (cfg_imm),
`endif
    .cfg_dly_i  (cfg_dly),
    .cfg_en_i   (cfg_en),
    .cfg_pend_o (pend_a)
  );

  pxs_split_n #(.NUM_OUT(NO), .MAX_DLY(5)) dut_b (
    .px_clk     (px_clk),
    .rst_n      (rst_n),
    .str_i      (str_i),
    .str_o      (str_o_b),
    .cfg_wr_i   (cfg_wr),
`ifdef PXS_SPLIT_IMM_EN
    .cfg_imm_i  (cfg_imm),
`endif
    .cfg_dly_i  (cfg_dly),
    .cfg_en_i   (cfg_en),
    .cfg_pend_o (pend_b)
  );

  int n_vec = 0;
  int n_bad = 0;
  int rcnt  = 16;

  // ------------------------------------------------------------ model
  // Output k after edge t = enabled ? word sampled at edge (t-1-delay) : 0,
  // using the config in force before edge t. Words before a reset read 0.
  int          maxd [2] = '{7, 5};
  logic [25:0] hist [HMAX];
  int          t         = 0;
  int          rst_floor = -1;
  logic        prev_vs   = 1'b0;
  int          act_d [2][NO];
  int          pnd_d [2][NO];
  bit          act_e [2][NO];
  bit          pnd_e [2][NO];
  bit          pnd   [2];
  logic [25:0] exp_o [2][NO];
  bit          exp_p [2];

  function automatic logic [25:0] word(input int i);
    if (i < 0 || i <= rst_floor || i >= HMAX) return '0;
    return hist[i];
  endfunction

  function automatic int clampf(input int m, input int k);
    int f;
    f = int'(cfg_dly[k*DW +: DW]);
    return (f > maxd[m]) ? maxd[m] : f;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < NO; k++) begin
        act_d[m][k] = 0; act_e[m][k] = 1'b1;
        pnd_d[m][k] = 0; pnd_e[m][k] = 1'b0;
        exp_o[m][k] = '0;
      end
      pnd[m]   = 1'b0;
      exp_p[m] = 1'b0;
    end
    prev_vs   = 1'b0;
    rst_floor = t - 1;
  endtask

  task automatic model_edge();
    bit fs;
    bit imm;
    if (!rst_n) begin
      model_reset();
      hist[t]   = '0;
      rst_floor = t;
      t++;
    end else begin
      fs  = str_i[25] && !prev_vs;
      imm = cfg_wr && cfg_imm;
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < NO; k++)
          exp_o[m][k] = act_e[m][k] ? word(t - 1 - act_d[m][k]) : 26'd0;
        if (imm) begin
          for (int k = 0; k < NO; k++) begin
            act_d[m][k] = clampf(m, k);
            act_e[m][k] = cfg_en[k];
          end
          pnd[m] = 1'b0;
        end else begin
          if (fs && pnd[m]) begin
            for (int k = 0; k < NO; k++) begin
              act_d[m][k] = pnd_d[m][k];
              act_e[m][k] = pnd_e[m][k];
            end
            pnd[m] = 1'b0;
          end
          if (cfg_wr) begin
            for (int k = 0; k < NO; k++) begin
              pnd_d[m][k] = clampf(m, k);
              pnd_e[m][k] = cfg_en[k];
            end
            pnd[m] = 1'b1;
          end
        end
        exp_p[m] = pnd[m];
      end
      hist[t] = str_i;
      prev_vs = str_i[25];
      t++;
    end
  endtask

  task automatic compare(input string tag);
    logic [NO*26-1:0] got;
    logic             gp;
    for (int m = 0; m < 2; m++) begin
      got = (m == 0) ? str_o_a : str_o_b;
      gp  = (m == 0) ? pend_a : pend_b;
      n_vec++;
      if (got[25:0] !== exp_o[m][0] || got[51:26] !== exp_o[m][1] || gp !== exp_p[m]) begin
        n_bad++;
        $display("FAIL %s dut%0d edge %0d: got o1=%h o0=%h pend=%b, want o1=%h o0=%h pend=%b",
                 tag, m, t - 1, got[51:26], got[25:0], gp, exp_o[m][1], exp_o[m][0], exp_p[m]);
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end else begin
      $display("check %s = %h", name, got);
    end
  endtask

  // One clock: model follows the edge, outputs are checked on the falling edge.
  task automatic step(input string tag);
    @(posedge px_clk);
    model_edge();
    @(negedge px_clk);
    compare(tag);
  endtask

  task automatic ramp(input int n, input logic vs, input string tag);
    for (int i = 0; i < n; i++) begin
      str_i = {vs, 1'b0, 24'(rcnt)};
      rcnt++;
      step(tag);
      cfg_wr = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_a", {12'd0, str_o_a}, 64'd0);
    chk("rst_async_b", {12'd0, str_o_b}, 64'd0);
    step("rst");
    rst_n = 1'b1;
  endtask

  // --------------------------------------------------------------- table
  typedef struct {
    logic [25:0]      str;
    logic             wr;
    logic [NO*DW-1:0] dly;
    logic [NO-1:0]    en;
    logic [25:0]      e0;
    logic [25:0]      e1;
    logic             ep;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [25:0] w;
    int          flen;
    int          fpos;

    // Reset defaults, then a mid-frame write of dly0=3/dly1=0 applied at the vsync rise.
    tbl[0] = '{26'd1,      1'b0, 6'd0,       2'b11, 26'd0,      26'd0,      1'b0};
    tbl[1] = '{26'd2,      1'b0, 6'd0,       2'b11, 26'd1,      26'd1,      1'b0};
    tbl[2] = '{26'd3,      1'b1, 6'b000011,  2'b11, 26'd2,      26'd2,      1'b1};
    tbl[3] = '{26'd4,      1'b0, 6'd0,       2'b11, 26'd3,      26'd3,      1'b1};
    tbl[4] = '{VS | 26'd5, 1'b0, 6'd0,       2'b11, 26'd4,      26'd4,      1'b0};
    tbl[5] = '{VS | 26'd6, 1'b0, 6'd0,       2'b11, 26'd2,      VS | 26'd5, 1'b0};
    tbl[6] = '{VS | 26'd7, 1'b0, 6'd0,       2'b11, 26'd3,      VS | 26'd6, 1'b0};
    tbl[7] = '{VS | 26'd8, 1'b0, 6'd0,       2'b11, 26'd4,      VS | 26'd7, 1'b0};
    tbl[8] = '{VS | 26'd9, 1'b0, 6'd0,       2'b11, VS | 26'd5, VS | 26'd8, 1'b0};
    tbl[9] = '{26'd10,     1'b0, 6'd0,       2'b11, VS | 26'd6, VS | 26'd9, 1'b0};

    model_reset();
    step("reset");
    step("reset");
    chk("rst_pend", {63'd0, pend_a}, 64'd0);
    rst_n = 1'b1;

    for (int r = 0; r < 10; r++) begin
      str_i   = tbl[r].str;
      cfg_wr  = tbl[r].wr;
      cfg_dly = tbl[r].dly;
      cfg_en  = tbl[r].en;
      step("tbl");
      n_vec++;
      if (str_o_a[25:0] !== tbl[r].e0 || str_o_a[51:26] !== tbl[r].e1 || pend_a !== tbl[r].ep) begin
        n_bad++;
        $display("FAIL tbl row %0d: got o1=%h o0=%h pend=%b, want o1=%h o0=%h pend=%b",
                 r, str_o_a[51:26], str_o_a[25:0], pend_a, tbl[r].e1, tbl[r].e0, tbl[r].ep);
      end else begin
        $display("row %0d: o1=%h o0=%h pend=%b", r, str_o_a[51:26], str_o_a[25:0], pend_a);
      end
    end
    cfg_wr = 1'b0;

    // Enable gating and clamp: output 1 off, dly0=7 (clamped to 5 on dut_b).
    cfg_wr = 1'b1; cfg_dly = {3'd0, 3'd7}; cfg_en = 2'b01;
    ramp(3, 1'b0, "clamp_wr");
    ramp(3, 1'b1, "clamp_vs");
    ramp(12, 1'b0, "clamp");
    chk("o1_disabled", {38'd0, str_o_a[51:26]}, 64'd0);
    w = {2'b00, 24'(rcnt)};
    ramp(9, 1'b0, "clamp_lag");
    chk("o0_lag9", {38'd0, str_o_a[25:0]}, {38'd0, w});

    // Collision: A pending, B written on the vsync-rise clock.
    cfg_wr = 1'b1; cfg_dly = {3'd1, 3'd2}; cfg_en = 2'b11;
    ramp(4, 1'b0, "coll_a");
    cfg_wr = 1'b1; cfg_dly = {3'd4, 3'd0}; cfg_en = 2'b10;
    ramp(1, 1'b1, "coll_b");
    chk("coll_pend", {63'd0, pend_a}, 64'd1);
    ramp(3, 1'b1, "coll");
    ramp(8, 1'b0, "coll");
    chk("coll_hold", {63'd0, pend_a}, 64'd1);
    ramp(1, 1'b1, "coll_apply");
    chk("coll_applied", {63'd0, pend_a}, 64'd0);
    ramp(3, 1'b1, "coll");
    ramp(10, 1'b0, "coll");

    // Reset mid-frame with dly={3,3} active.
    cfg_wr = 1'b1; cfg_dly = {3'd3, 3'd3}; cfg_en = 2'b11;
    ramp(2, 1'b0, "pre_rst");
    ramp(2, 1'b1, "pre_rst");
    ramp(8, 1'b0, "pre_rst");
    do_reset();
    w = {2'b00, 24'(rcnt)};
    ramp(2, 1'b0, "post_rst");
    chk("post_rst_o0", {38'd0, str_o_a[25:0]}, {38'd0, w});
    chk("post_rst_o1", {38'd0, str_o_a[51:26]}, {38'd0, w});
    ramp(4, 1'b0, "post_rst");

`ifdef PXS_SPLIT_IMM_EN
    // Immediate write mid-frame: no wait for vsync, pend stays low.
    cfg_wr = 1'b1; cfg_imm = 1'b1; cfg_dly = {3'd0, 3'd2}; cfg_en = 2'b11;
    ramp(1, 1'b0, "imm");
    chk("imm_pend", {63'd0, pend_a}, 64'd0);
    cfg_imm = 1'b0;
    ramp(6, 1'b0, "imm");
`endif

    // Random traffic with frames of random length.
    flen = 30;
    fpos = 0;
    for (int i = 0; i < 2000; i++) begin
      if (fpos >= flen) begin
        fpos = 0;
        flen = int'($urandom_range(12, 48));
      end
      str_i   = {(fpos < 3) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)), 24'($urandom)};
      cfg_wr  = ($urandom_range(0, 7) == 0);
      cfg_dly = (NO*DW)'($urandom);
      cfg_en  = NO'($urandom);
`ifdef PXS_SPLIT_IMM_EN
      cfg_imm = ($urandom_range(0, 3) == 0);
`endif
      step("rnd");
      fpos++;
      if ($urandom_range(0, 799) == 0) begin
        cfg_wr = 1'b0;
        do_reset();
      end
    end
    cfg_wr  = 1'b0;
    cfg_imm = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
